// File: rtl/mult_bcd_converter_if.sv
// mult_bcd_converter_if: start/busy/done handshake and BCD result bundle for the converter
interface mult_bcd_converter_if #(
  parameter int N = 16,
  parameter int DIGITS = 5
);
  logic start;
  logic [N-1:0] bin_in;
  logic busy;
  logic done;
  logic [4*DIGITS-1:0] bcd_out;
  logic [DIGITS-1:0] digit_nz;
  logic overflow;
  modport master (output start, bin_in, input busy, done, bcd_out, digit_nz, overflow);
  modport slave (input start, bin_in, output busy, done, bcd_out, digit_nz, overflow);
endinterface

// File: rtl/mult_bcd_converter.sv
// mult_bcd_converter: sequential double-dabble binary-to-BCD, one bit per clock
module mult_bcd_converter #(
  parameter int N = 16,
  parameter int DIGITS = 5
) (
  input logic clk,
  input logic reset,
  mult_bcd_converter_if.slave bus
);
  localparam int W = 4 * DIGITS;
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;
  state_t state_q, state_d;
  logic [N-1:0] bin_q, bin_d;
  logic [W-1:0] bcd_q, bcd_d, corr;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d;
  logic [W-1:0] out_q, out_d;
  logic [DIGITS-1:0] nz_q, nz_d, nz;
  logic ovo_q, ovo_d;
  logic done_q, done_d;
  logic acc;
  for (genvar i = 0; i < DIGITS; i++) begin : g_corr
    assign corr[4*i+:4] = bcd_q[4*i+:4] >= 4'd5 ? bcd_q[4*i+:4] + 4'd3 : bcd_q[4*i+:4];
  end
  // Leading-zero mask accumulates from the most significant digit down; ones digit always shown
  always_comb begin
    nz = '0;
    acc = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      acc = acc | (|bcd_q[4*i+:4]);
      nz[i] = acc;
    end
    nz[0] = 1'b1;
  end
  always_comb begin
    state_d = state_q;
    bin_d = bin_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    out_d = out_q;
    nz_d = nz_q;
    ovo_d = ovo_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        bin_d = bus.bin_in;
        bcd_d = '0;
        cnt_d = CW'(N);
        ovf_d = 1'b0;
        state_d = SHIFT;
      end
      SHIFT: begin
        bcd_d = {corr[W-2:0], bin_q[N-1]};
        bin_d = {bin_q[N-2:0], 1'b0};
        ovf_d = ovf_q | corr[W-1];
        cnt_d = cnt_q - 1'b1;
        state_d = cnt_q == CW'(1) ? FINISH : SHIFT;
      end
      FINISH: begin
        out_d = bcd_q;
        nz_d = nz;
        ovo_d = ovf_q;
        done_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      out_q <= '0;
      nz_q <= '0;
      ovo_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      out_q <= out_d;
      nz_q <= nz_d;
      ovo_q <= ovo_d;
      done_q <= done_d;
    end
  end
  assign bus.busy = state_q != IDLE;
  assign bus.done = done_q;
  assign bus.bcd_out = out_q;
  assign bus.digit_nz = nz_q;
  assign bus.overflow = ovo_q;
endmodule

// File: tb/tb_mult_bcd_converter.sv
// tb_mult_bcd_converter: directed scoreboard bench for 5-digit and 4-digit converter instances
module tb_mult_bcd_converter;
  typedef struct {
    logic [19:0] bcd;
    logic [4:0] nz;
    logic ovf;
    int due;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  exp_t q5[$];
  exp_t q4[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  mult_bcd_converter_if #(.N(16), .DIGITS(5)) bus ();
  mult_bcd_converter_if #(.N(16), .DIGITS(4)) bus4 ();
  assign bus4.start = bus.start;
  assign bus4.bin_in = bus.bin_in;
  mult_bcd_converter #(.N(16), .DIGITS(5)) dut (.clk(clk), .reset(reset), .bus(bus));
  mult_bcd_converter #(.N(16), .DIGITS(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
  function automatic exp_t model(int v, int d, int due);
    exp_t e;
    int tv;
    int t;
    tv = v % (10 ** d);
    t = tv;
    e.bcd = '0;
    e.nz = '0;
    e.ovf = v >= 10 ** d;
    e.due = due;
    for (int i = 0; i < d; i++) begin
      e.bcd[4*i+:4] = 4'(t % 10);
      t = t / 10;
      e.nz[i] = tv >= 10 ** i;
    end
    e.nz[0] = 1'b1;
    return e;
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) if (bus.done === 1'b1) begin
    if (q5.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL spurious_done5 observed done=1 expected no pending conversion");
    end else begin
      exp_t e;
      e = q5.pop_front();
      chk("bcd5", 32'(bus.bcd_out), 32'(e.bcd));
      chk("nz5", 32'(bus.digit_nz), 32'(e.nz));
      chk("ovf5", 32'(bus.overflow), 32'(e.ovf));
      chk("latency5", 32'(cyc), 32'(e.due));
    end
  end
  always @(negedge clk) if (bus4.done === 1'b1) begin
    if (q4.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL spurious_done4 observed done=1 expected no pending conversion");
    end else begin
      exp_t e;
      e = q4.pop_front();
      chk("bcd4", 32'(bus4.bcd_out), 32'(e.bcd[15:0]));
      chk("nz4", 32'(bus4.digit_nz), 32'(e.nz[3:0]));
      chk("ovf4", 32'(bus4.overflow), 32'(e.ovf));
      chk("latency4", 32'(cyc), 32'(e.due));
    end
  end
  task automatic go(int v);
    bus.start = 1'b1;
    bus.bin_in = 16'(v);
    q5.push_back(model(v, 5, cyc + 18));
    q4.push_back(model(v, 4, cyc + 18));
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  task automatic drain();
    for (int i = 0; i < 60 && (q5.size() != 0 || q4.size() != 0); i++) @(negedge clk);
    if (q5.size() != 0 || q4.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL drain_timeout observed pending=%0d expected 0", q5.size() + q4.size());
      q5.delete();
      q4.delete();
    end
  endtask
  initial begin
    bus.start = 1'b0;
    bus.bin_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_bcd", 32'(bus.bcd_out), 0);
    chk("rst_nz", 32'(bus.digit_nz), 0);
    chk("rst_ovf", 32'(bus.overflow), 0);
    reset = 1'b0;
    @(negedge clk);
    go(56);
    chk("busy_run", 32'(bus.busy), 1);
    drain();
    @(negedge clk);
    go(84);
    drain();
    @(negedge clk);
    go(0);
    drain();
    @(negedge clk);
    go(65535);
    drain();
    @(negedge clk);
    go(56);
    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    bus.bin_in = 16'd99;
    @(negedge clk);
    bus.start = 1'b0;
    bus.bin_in = 16'd1111;
    chk("busy_ignore", 32'(bus.busy), 1);
    drain();
    repeat (25) @(negedge clk);
    go(4321);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    q5.delete();
    q4.delete();
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_done", 32'(bus.done), 0);
    chk("abort_bcd", 32'(bus.bcd_out), 0);
    chk("abort_nz", 32'(bus.digit_nz), 0);
    repeat (25) @(negedge clk);
    go(84);
    drain();
    @(negedge clk);
    go(56);
    for (int i = 0; i < 40 && bus.done !== 1'b1; i++) @(negedge clk);
    chk("b2b_done_seen", 32'(bus.done), 1);
    go(1234);
    drain();
    repeat (25) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
